// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_W     = 32;
  localparam int UART_FRAME_BITS = 35;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_e;

  // Larger of two integers; used to size the shared frame/gap counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first set request at or above
// ptr, wrapping around, using a doubled request vector masked below ptr.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] mask;
  logic [2*N_REQ-1:0] masked;

  // Mask off the lower copy below ptr; the upper copy supplies the wrap-around.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    req_dbl = {req, req};
    mask    = {(2*N_REQ){1'b1}} << ptr;
    masked  = req_dbl & mask;
    winner  = '0;
    valid   = |req;
    // Scanning downward means the lowest set bit is the last one written.
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (masked[i]) begin
        if (i >= N_REQ) winner = ID_W'(i - N_REQ);
        else            winner = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters:
// grants, latches the winner's word, strobes the transmitter, then counts
// baud ticks through the frame and the inter-frame gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_W     = UART_DATA_W,
  parameter  int FRAME_BITS = UART_FRAME_BITS,
  parameter  int GAP_TICKS  = 1,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                    Clock_In,
  input  logic                    Reset,
  input  logic                    Baud_Tick,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ*DATA_W-1:0] Req_Data,
  output logic [N_REQ-1:0]        Grant,
  output logic                    Tx_start,
  output logic [DATA_W-1:0]       Tx_Data,
  output logic                    Busy,
  output logic [ID_W-1:0]         Cur_Id
);

  localparam int CNT_W = $clog2(max_int(FRAME_BITS, GAP_TICKS) + 1);

  state_e             state_q,    state_d;
  logic [ID_W-1:0]    ptr_q,      ptr_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [N_REQ-1:0]   grant_q,    grant_d;
  logic               tx_start_q, tx_start_d;
  logic [DATA_W-1:0]  tx_data_q,  tx_data_d;
  logic [ID_W-1:0]    cur_id_q,   cur_id_d;

  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req    (Req),
    .ptr    (ptr_q),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  // Next-state, tick counter and output strobes for the grant/frame/gap cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_d    = '0;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    cur_id_d   = cur_id_q;

    unique case (state_q)
      IDLE: begin
        tx_start_d = 1'b0;
        if (pick_valid) begin
          grant_d    = N_REQ'(1) << pick_id;
          tx_data_d  = Req_Data[int'(pick_id)*DATA_W +: DATA_W];
          cur_id_d   = pick_id;
          tx_start_d = 1'b1;
          ptr_d      = (pick_id == ID_W'(N_REQ-1)) ? '0 : pick_id + ID_W'(1);
          state_d    = LOAD;
        end
      end
      // The first tick seen here is the start bit; it may arrive immediately.
      LOAD: begin
        if (Baud_Tick) begin
          tx_start_d = 1'b0;
          cnt_d      = CNT_W'(FRAME_BITS - 1);
          state_d    = SEND;
        end
      end
      SEND: begin
        if (Baud_Tick) begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(GAP_TICKS);
            state_d = (GAP_TICKS == 0) ? IDLE : GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (Baud_Tick) begin
          if (cnt_q <= CNT_W'(1)) state_d = IDLE;
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge Clock_In) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      cur_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cur_id_q   <= cur_id_d;
    end
  end

  assign Grant    = grant_q;
  assign Tx_start = tx_start_q;
  assign Tx_Data  = tx_data_q;
  assign Busy     = (state_q != IDLE);
  assign Cur_Id   = cur_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: two arbiters (GAP_TICKS=1 and GAP_TICKS=0) share the
// same stimulus; a tick-budget reference model feeds a grant scoreboard and
// per-cycle expectations, plus directed scenarios with fixed expectations.
module tb_uart_tx_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_W     = 32;
  localparam int FRAME_BITS = 35;
  localparam int ID_W       = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    baud = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;

  logic [N_REQ-1:0]  grant_w    [2];
  logic              tx_start_w [2];
  logic [DATA_W-1:0] tx_data_w  [2];
  logic              busy_w     [2];
  logic [ID_W-1:0]   cur_id_w   [2];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS), .GAP_TICKS(1)) dut_gap1 (
    .Clock_In(clk), .Reset(rst), .Baud_Tick(baud), .Req(req), .Req_Data(req_data),
    .Grant(grant_w[0]), .Tx_start(tx_start_w[0]), .Tx_Data(tx_data_w[0]),
    .Busy(busy_w[0]), .Cur_Id(cur_id_w[0]));

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS), .GAP_TICKS(0)) dut_gap0 (
    .Clock_In(clk), .Reset(rst), .Baud_Tick(baud), .Req(req), .Req_Data(req_data),
    .Grant(grant_w[1]), .Tx_start(tx_start_w[1]), .Tx_Data(tx_data_w[1]),
    .Busy(busy_w[1]), .Cur_Id(cur_id_w[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int gap_of(input int g);
    return (g == 0) ? 1 : 0;
  endfunction

  // Ticks a granted frame occupies: start tick, frame bits, gap.
  function automatic int frame_total(input int g);
    return 1 + FRAME_BITS + gap_of(g);
  endfunction

  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return 0;
  endfunction

  function automatic exp_t mk_exp(input logic [N_REQ*DATA_W-1:0] rd, input int w);
    exp_t e;
    e.id   = ID_W'(w);
    e.data = rd[w*DATA_W +: DATA_W];
    return e;
  endfunction

  int               m_rem  [2];  // ticks still owed by the current frame; 0 = idle
  int               m_ptr  [2];
  exp_t             m_last [2];
  logic [N_REQ-1:0] m_gnt  [2];
  exp_t             exp_q0 [$];
  exp_t             exp_q1 [$];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_rem[g]  <= 0;
        m_ptr[g]  <= 0;
        m_last[g] <= '0;
        m_gnt[g]  <= '0;
      end else if (m_rem[g] == 0) begin
        if (req != '0) begin
          m_rem[g]  <= frame_total(g);
          m_ptr[g]  <= (rr_pick(req, m_ptr[g]) + 1) % N_REQ;
          m_last[g] <= mk_exp(req_data, rr_pick(req, m_ptr[g]));
          m_gnt[g]  <= N_REQ'(1) << rr_pick(req, m_ptr[g]);
          if (g == 0) exp_q0.push_back(mk_exp(req_data, rr_pick(req, m_ptr[g])));
          else        exp_q1.push_back(mk_exp(req_data, rr_pick(req, m_ptr[g])));
        end else begin
          m_gnt[g] <= '0;
        end
      end else begin
        m_gnt[g] <= '0;
        if (baud) m_rem[g] <= m_rem[g] - 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 2; g++) begin
        check($sformatf("grant_%0d", g), grant_w[g], m_gnt[g]);
        check($sformatf("busy_%0d", g), busy_w[g], m_rem[g] != 0);
        check($sformatf("tx_start_%0d", g), tx_start_w[g], m_rem[g] == frame_total(g));
        check($sformatf("tx_data_%0d", g), tx_data_w[g], m_last[g].data);
        check($sformatf("cur_id_%0d", g), cur_id_w[g], m_last[g].id);
        if (grant_w[g] != '0) begin
          exp_t e;
          int   qs;
          qs = (g == 0) ? exp_q0.size() : exp_q1.size();
          check($sformatf("sb_pending_%0d", g), qs > 0, 1);
          if (qs > 0) begin
            e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("sb_grant_%0d", g), grant_w[g], N_REQ'(1) << e.id);
            check($sformatf("sb_id_%0d", g), cur_id_w[g], e.id);
            check($sformatf("sb_data_%0d", g), tx_data_w[g], e.data);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  // Leaves the bench at the negedge where instance g shows a Grant.
  task automatic wait_grant(input int g, input string name, output int id);
    bit found = 1'b0;
    id = -1;
    for (int c = 0; c < 400 && !found; c++) begin
      if (grant_w[g] != '0) found = 1'b1;
      else step();
    end
    check({name, "_no_timeout"}, found, 1);
    for (int i = 0; i < N_REQ; i++) if (grant_w[g][i]) id = i;
  endtask

  initial begin
    int id;
    int busy_n0, busy_n1, start_n, idle_n;

    step();
    do_reset();
    mon_en = 1'b1;

    // Reset values on both instances.
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_grant_%0d", g), grant_w[g], 0);
      check($sformatf("rst_start_%0d", g), tx_start_w[g], 0);
      check($sformatf("rst_data_%0d", g), tx_data_w[g], 0);
      check($sformatf("rst_busy_%0d", g), busy_w[g], 0);
      check($sformatf("rst_id_%0d", g), cur_id_w[g], 0);
    end

    // Single request, tick every cycle (tick also lands in LOAD's first cycle).
    baud = 1'b1;
    req  = 4'b0010;
    req_data = '0;
    req_data[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
    step();
    check("single_grant", grant_w[0], 4'b0010);
    check("single_data", tx_data_w[0], 32'hDEADBEEF);
    check("single_start", tx_start_w[0], 1);
    req = '0;
    req_data[1*DATA_W +: DATA_W] = 32'h12345678;
    busy_n0 = 0; busy_n1 = 0; start_n = 0;
    for (int c = 0; c < 200 && (busy_w[0] || busy_w[1]); c++) begin
      if (busy_w[0])     busy_n0++;
      if (busy_w[1])     busy_n1++;
      if (tx_start_w[0]) start_n++;
      step();
    end
    check("single_busy_ticks_gap1", busy_n0, 37);
    check("single_busy_ticks_gap0", busy_n1, 36);
    check("single_start_cycles", start_n, 1);
    check("single_data_hold", tx_data_w[0], 32'hDEADBEEF);

    // All requests held: strict rotation 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
    for (int n = 0; n < 5; n++) begin
      wait_grant(0, "rotate", id);
      check($sformatf("rotate_order_%0d", n), id, n % N_REQ);
      check($sformatf("rotate_cur_id_%0d", n), cur_id_w[0], n % N_REQ);
      step();
    end

    // Wrap and skip: grant 2 sets ptr=3, then 0101 gives 0 then 2.
    do_reset();
    req = 4'b0100;
    step();
    check("wrap_first", grant_w[0], 4'b0100);
    req = 4'b0101;
    step();
    wait_grant(0, "wrap", id);
    check("wrap_to_0", grant_w[0], 4'b0001);
    step();
    wait_grant(0, "skip", id);
    check("skip_to_2", grant_w[0], 4'b0100);
    step();

    // Reset in SEND after the start tick plus 20 frame ticks.
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b1000;
    for (int c = 0; c < 21; c++) step();
    check("abort_in_frame", busy_w[0], 1);
    rst = 1'b1;
    step();
    check("abort_busy", busy_w[0], 0);
    check("abort_start", tx_start_w[0], 0);
    check("abort_data", tx_data_w[0], 0);
    check("abort_grant", grant_w[0], 0);
    check("abort_id", cur_id_w[0], 0);
    rst = 1'b0;
    step();
    check("abort_regrant", grant_w[0], 4'b1000);

    // GAP_TICKS=0 instance: exactly one idle cycle between back-to-back frames.
    do_reset();
    req = 4'b1111;
    wait_grant(1, "gap0_first", id);
    step();
    idle_n = 0;
    for (int c = 0; c < 200 && grant_w[1] == '0; c++) begin
      if (!busy_w[1]) idle_n++;
      step();
    end
    check("gap0_next_grant", grant_w[1] != '0, 1);
    check("gap0_idle_cycles", idle_n, 1);

    // Randomized traffic checked by the model and scoreboard.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      baud = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) req = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++)
        if ($urandom_range(0, 3) == 0) req_data[i*DATA_W +: DATA_W] = $urandom;
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst  = 1'b0;
    req  = '0;
    baud = 1'b1;
    for (int c = 0; c < 100; c++) step();
    check("drain_idle_0", busy_w[0], 0);
    check("drain_idle_1", busy_w[1], 0);
    check("sb_left_0", exp_q0.size(), 0);
    check("sb_left_1", exp_q1.size(), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
